// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for the RV32 load/store stage: one request at a time, programmable
// wait states, word-addressed RAM. Optional macro RV32_DMEM_MISALIGN_TRAP_EN faults misaligned accesses.
module rv32_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WaitLoad  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        latch;
    logic        enter_resp;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the response is formed on the accepting edge, so the live
    // request is used while idle and the latched copy otherwise.
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [2:0]    cur_funct3;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;

    assign cur_we     = (state_q == StIdle) ? req_we     : we_q;
    assign cur_addr   = (state_q == StIdle) ? req_addr   : addr_q;
    assign cur_funct3 = (state_q == StIdle) ? req_funct3 : funct3_q;
    assign cur_wdata  = (state_q == StIdle) ? req_wdata  : wdata_q;
    assign word_idx   = cur_addr[2 +: AW];
    assign rd_word    = mem[word_idx];

    logic out_of_range, bad_funct3, misalign, acc_err;

    always_comb begin
        out_of_range = ({1'b0, cur_addr} >= ByteLimit);
        if (cur_we) begin
            bad_funct3 = (cur_funct3 > 3'd2);
        end else begin
            case (cur_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: bad_funct3 = 1'b0;
                default:                      bad_funct3 = 1'b1;
            endcase
        end
`ifdef RV32_DMEM_MISALIGN_TRAP_EN
        case (cur_funct3[1:0])
            2'b01:   misalign = cur_addr[0];
            2'b10:   misalign = (cur_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
`else
        misalign = 1'b0;
`endif
        acc_err = out_of_range | bad_funct3 | misalign;
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = 8'(rd_word >> {cur_addr[1:0], 3'b000});
        ld_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_funct3)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd2:    ld_data = rd_word;
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] wr_word;

    always_comb begin
        st_be   = 4'b0000;
        st_data = cur_wdata;
        case (cur_funct3)
            3'd0: begin
                st_be   = 4'b0001 << cur_addr[1:0];
                st_data = {4{cur_wdata[7:0]}};
            end
            3'd1: begin
                st_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{cur_wdata[15:0]}};
            end
            3'd2:    st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = st_be[i] ? st_data[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    latch = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (rst) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end
        // A reset in the same cycle forces StIdle above, so an uncommitted store is dropped.
        enter_resp = (state_d == StResp) && (state_q != StResp);
        mem_we     = enter_resp && cur_we && !acc_err;
        rdata_d    = (enter_resp && !cur_we && !acc_err) ? ld_data : 32'd0;
        err_d      = enter_resp && acc_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (latch) begin
                we_q     <= req_we;
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_word;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/rv32_dmem_responder.md
Name: rv32_dmem_responder

Overview:
- Data-memory responder for the RV32 pipeline's load/store stage.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then commits the store or returns the sign/zero-extended load data with an error flag.
- Backed by an internal word-addressed RAM. The memory stage drives the request side.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of 2, >=4)
WAIT_STATES, 1, cycles spent in WAIT between acceptance and response (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_funct3  input  3  RV32 load/store funct3 (width/signedness)
req_wdata  input  32  store data, LSB-aligned
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  extended load data (0 for stores and errors)
rsp_err  output  1  request faulted; qualified by rsp_valid
busy  output  1  request in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid=1, latch we/addr/funct3/wdata. Go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: down-counter loaded with WAIT_STATES-1. Go to RESP on the cycle the counter is 0.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure; the consumer must sample it.
- req_ready is 0 in WAIT and RESP; requests offered then are ignored and must be held by the initiator.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accepting edge. Maximum throughput is one request per WAIT_STATES+2 cycles.
- Registered outputs: rsp_rdata and rsp_err are valid in the RESP cycle and return to 0 in all other cycles.
- Word index: req_addr[2 +: log2(DEPTH_WORDS)].
- Range check: if req_addr >= DEPTH_WORDS*4, then rsp_err=1, no write, rdata=0.
- Legal funct3:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other value: rsp_err=1, no write, rdata=0.
- Load lane selection: LB/LBU use byte addr[1:0]; LH/LHU use halfword addr[1]; LW uses the whole word. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Store byte enables:
  - SB writes wdata[7:0] into byte lane addr[1:0].
  - SH writes wdata[15:0] into halfword lane addr[1].
  - SW writes the whole word.
  - Unselected bytes are preserved.
- Store commit timing: the store commits on the clock edge that enters RESP. A load issued after a store to the same address returns the new data.
- Reset mid-operation: abort to IDLE. A store not yet committed (still in WAIT) is dropped. No response is produced.
- rst has priority over every other event in the same cycle.

Optional Feature:
Macro: RV32_DMEM_MISALIGN_TRAP_EN
- Defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, gives rsp_err=1, no write, rdata=0.
- Not defined: misaligned low address bits are ignored. Halfword accesses use addr[1] only; word accesses ignore addr[1:0].

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> LW response rsp_rdata=0xDEADBEEF, rsp_err=0. With WAIT_STATES=1, rsp_valid comes 2 cycles after each accept; req_ready is 0 during WAIT and RESP.
- Byte and halfword loads after the SW (0xDEADBEEF at 0x10):
  - LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE
  - LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF. SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- Errors:
  - LW addr DEPTH_WORDS*4 -> rsp_err=1, rdata=0.
  - SW with funct3=3 -> rsp_err=1, and a following LW of word 0 is unchanged.
- Assert rst during WAIT of SW 0x20 data 0xA5A5A5A5 -> no rsp_valid, state IDLE. LW 0x20 then returns the prior contents.
- Misalignment: LW 0x11 -> with the macro, rsp_err=1 and rdata=0; without it, rsp_err=0 and the word at 0x10 is returned. Repeat all scenarios with WAIT_STATES=0 and WAIT_STATES=3 for latencies of 1 and 4 cycles.
